// File: rtl/ps2_line_assembler.sv
// Command-line builder for the PS/2 printer path: edits a line from ASCII key events,
// commits it on ENTER as a packed word (char 0 in the MSB byte), then wipes the edit buffer.
//
// state   | meaning
// S_EDIT  | accepting key events, editing buffer at cursor
// S_CLEAR | wiping buffer one char per cycle after a commit
module ps2_line_assembler #(
  parameter int LINE_CHARS = 32,
  parameter int CHAR_W = 8,
  parameter logic [CHAR_W-1:0] ENTER_CODE = 8'h0D,
  parameter logic [CHAR_W-1:0] BKSP_CODE = 8'h08,
  parameter logic [CHAR_W-1:0] FILL_CODE = 8'h00
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 key_valid,
  input  logic [CHAR_W-1:0]                    key_ascii,
  output logic                                 key_ready,
  output logic [LINE_CHARS*CHAR_W-1:0]         edit_content,
  output logic [$clog2(LINE_CHARS+1)-1:0]      cursor,
  output logic [LINE_CHARS*CHAR_W-1:0]         line_content,
  output logic                                 line_ready,
  input  logic                                 line_ack,
  output logic                                 overflow
);

  localparam int CW = $clog2(LINE_CHARS + 1);
  localparam int IW = $clog2(LINE_CHARS);
  localparam int LW = LINE_CHARS * CHAR_W;
  localparam logic [CW-1:0] CUR_MAX = CW'(LINE_CHARS);
  localparam logic [IW-1:0] IDX_LAST = IW'(LINE_CHARS - 1);

  typedef enum logic {S_EDIT = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CHAR_W-1:0] buf_q [LINE_CHARS];
  logic [CHAR_W-1:0] buf_d [LINE_CHARS];
  logic [CW-1:0]     cursor_q, cursor_d;
  logic [CW-1:0]     cur_m1;
  logic [IW-1:0]     clr_idx_q, clr_idx_d;
  logic [LW-1:0]     line_q, line_d;
  logic              line_ready_q, line_ready_d;
  logic              overflow_q, overflow_d;

  for (genvar i = 0; i < LINE_CHARS; i++) begin : g_pack
    assign edit_content[LW-1-CHAR_W*i -: CHAR_W] = buf_q[i];
  end

  assign key_ready    = (state_q == S_EDIT);
  assign cursor       = cursor_q;
  assign line_content = line_q;
  assign line_ready   = line_ready_q;
  assign overflow     = overflow_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_EDIT;
      for (int i = 0; i < LINE_CHARS; i++) buf_q[i] <= FILL_CODE;
      cursor_q     <= '0;
      clr_idx_q    <= '0;
      line_q       <= {LINE_CHARS{FILL_CODE}};
      line_ready_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      cursor_q     <= cursor_d;
      clr_idx_q    <= clr_idx_d;
      line_q       <= line_d;
      line_ready_q <= line_ready_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    cursor_d     = cursor_q;
    clr_idx_d    = clr_idx_q;
    line_d       = line_q;
    overflow_d   = 1'b0;
    line_ready_d = line_ready_q & ~line_ack;
    cur_m1       = cursor_q - CW'(1);
    case (state_q)
      S_EDIT: begin
        if (key_valid) begin
          if (key_ascii == ENTER_CODE) begin
            // A same-edge ack frees the slot, so the new line may replace the old one.
            if (!line_ready_q || line_ack) begin
              line_d       = edit_content;
              line_ready_d = 1'b1;
              clr_idx_d    = '0;
              state_d      = S_CLEAR;
            end else begin
              overflow_d = 1'b1;
            end
          end else if (key_ascii == BKSP_CODE) begin
            if (cursor_q != '0) begin
              buf_d[cur_m1[IW-1:0]] = FILL_CODE;
              cursor_d              = cur_m1;
            end
          end else if (cursor_q < CUR_MAX) begin
            buf_d[cursor_q[IW-1:0]] = key_ascii;
            cursor_d                = cursor_q + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        buf_d[clr_idx_q] = FILL_CODE;
        clr_idx_d        = clr_idx_q + IW'(1);
        if (clr_idx_q == IDX_LAST) begin
          cursor_d = '0;
          state_d  = S_EDIT;
        end
      end
      default: state_d = S_EDIT;
    endcase
  end

endmodule

// File: tb/tb_ps2_line_assembler.sv
// Directed bench for ps2_line_assembler: editing, commit/clear sequence,
// line-full and busy-line overflow, ack handshake and reset during clear.
module tb_ps2_line_assembler;

  logic         clock = 1'b0;
  logic         reset;
  logic         key_valid;
  logic [7:0]   key_ascii;
  logic         key_ready;
  logic [255:0] edit_content;
  logic [5:0]   cursor;
  logic [255:0] line_content;
  logic         line_ready;
  logic         line_ack;
  logic         overflow;

  int n_tests = 0;
  int n_fail  = 0;

  ps2_line_assembler dut (
    .clock        (clock),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_ascii    (key_ascii),
    .key_ready    (key_ready),
    .edit_content (edit_content),
    .cursor       (cursor),
    .line_content (line_content),
    .line_ready   (line_ready),
    .line_ack     (line_ack),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    reset     = 1'b1;
    key_valid = 1'b0;
    key_ascii = 8'h00;
    line_ack  = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One key event (optionally with ack) presented for one edge; returns #1 after that edge.
  task automatic send_key(input logic [7:0] code, input logic ack);
    @(negedge clock);
    key_valid = 1'b1;
    key_ascii = code;
    line_ack  = ack;
    @(posedge clock);
    #1;
    key_valid = 1'b0;
    line_ack  = 1'b0;
  endtask

  task automatic wait_clear(output int cycles);
    cycles = 0;
    while (key_ready !== 1'b1 && cycles < 100) begin
      @(posedge clock);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    key_valid = 1'b0;
    key_ascii = 8'h00;
    line_ack  = 1'b0;
    #12;
    n_tests++;
    if (key_ready !== 1'b1 || cursor !== 6'd0 || edit_content !== 256'd0 ||
        line_content !== 256'd0 || line_ready !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: kr=%b cur=%0d edit=%h line=%h lr=%b ov=%b, want kr=1 cur=0 all zero",
               key_ready, cursor, edit_content, line_content, line_ready, overflow);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic_typing();
    do_reset();
    send_key(8'h4C, 1'b0);
    send_key(8'h53, 1'b0);
    n_tests++;
    if (edit_content[255:240] !== 16'h4C53 || edit_content[239:0] !== 240'd0) begin
      n_fail++;
      $display("FAIL typing_content: got %h want 4c53 then zeros", edit_content);
    end
    n_tests++;
    if (cursor !== 6'd2 || line_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL typing_cursor: cur=%0d lr=%b want cur=2 lr=0", cursor, line_ready);
    end
  endtask

  task automatic test_backspace();
    do_reset();
    send_key(8'h41, 1'b0);
    send_key(8'h42, 1'b0);
    send_key(8'h08, 1'b0);
    n_tests++;
    if (cursor !== 6'd1 || edit_content[255:240] !== 16'h4100) begin
      n_fail++;
      $display("FAIL bksp_erase: cur=%0d top=%h want cur=1 top=4100", cursor, edit_content[255:240]);
    end
    send_key(8'h43, 1'b0);
    n_tests++;
    if (cursor !== 6'd2 || edit_content[255:240] !== 16'h4143 || edit_content[239:0] !== 240'd0) begin
      n_fail++;
      $display("FAIL bksp_retype: cur=%0d edit=%h want cur=2 top=4143", cursor, edit_content);
    end
    do_reset();
    send_key(8'h08, 1'b0);
    n_tests++;
    if (cursor !== 6'd0 || overflow !== 1'b0 || edit_content !== 256'd0) begin
      n_fail++;
      $display("FAIL bksp_at_zero: cur=%0d ov=%b edit=%h want cur=0 ov=0 edit=0",
               cursor, overflow, edit_content);
    end
  endtask

  task automatic test_commit_clear();
    int  cyc;
    bit  ov_seen;
    do_reset();
    send_key(8'h52, 1'b0);
    send_key(8'h55, 1'b0);
    send_key(8'h4E, 1'b0);
    send_key(8'h0D, 1'b0);
    n_tests++;
    if (line_content[255:232] !== 24'h52554E || line_content[231:0] !== 232'd0 || line_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_line: line=%h lr=%b want 52554e.. lr=1", line_content, line_ready);
    end
    n_tests++;
    if (key_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_keyready: got %b want 0", key_ready);
    end
    // Hold a key during the clear; it must be ignored.
    key_valid = 1'b1;
    key_ascii = 8'h5A;
    cyc = 0;
    ov_seen = 1'b0;
    while (key_ready !== 1'b1 && cyc < 100) begin
      @(posedge clock);
      #1;
      cyc++;
      if (overflow === 1'b1) ov_seen = 1'b1;
    end
    key_valid = 1'b0;
    n_tests++;
    if (cyc != 32) begin
      n_fail++;
      $display("FAIL clear_cycles: got %0d want 32", cyc);
    end
    n_tests++;
    if (edit_content !== 256'd0 || cursor !== 6'd0 || ov_seen) begin
      n_fail++;
      $display("FAIL clear_result: edit=%h cur=%0d ov_seen=%b want 0 0 0", edit_content, cursor, ov_seen);
    end
    n_tests++;
    if (line_content[255:232] !== 24'h52554E || line_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL line_stable: line=%h lr=%b want 52554e.. lr=1", line_content, line_ready);
    end
  endtask

  task automatic test_line_full();
    logic [255:0] exp_buf;
    logic [7:0]   ch;
    exp_buf = '0;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      ch = 8'h41 + 8'(i % 26);
      exp_buf[255-8*i -: 8] = ch;
      send_key(ch, 1'b0);
    end
    n_tests++;
    if (cursor !== 6'd32 || edit_content !== exp_buf || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_fill: cur=%0d edit=%h ov=%b want cur=32 edit=%h ov=0",
               cursor, edit_content, overflow, exp_buf);
    end
    send_key(8'h21, 1'b0);
    n_tests++;
    if (overflow !== 1'b1 || cursor !== 6'd32 || edit_content !== exp_buf) begin
      n_fail++;
      $display("FAIL full_drop: ov=%b cur=%0d edit=%h want ov=1 cur=32 unchanged", overflow, cursor, edit_content);
    end
    @(posedge clock);
    #1;
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pulse: ov=%b want 0 one cycle later", overflow);
    end
    send_key(8'h08, 1'b0);
    exp_buf[7:0] = 8'h00;
    n_tests++;
    if (cursor !== 6'd31 || edit_content !== exp_buf) begin
      n_fail++;
      $display("FAIL full_bksp: cur=%0d edit=%h want cur=31 edit=%h", cursor, edit_content, exp_buf);
    end
  endtask

  task automatic test_busy_and_ack();
    int cyc;
    do_reset();
    send_key(8'h48, 1'b0);
    send_key(8'h49, 1'b0);
    send_key(8'h0D, 1'b0);
    wait_clear(cyc);
    n_tests++;
    if (cyc != 32) begin
      n_fail++;
      $display("FAIL busy_clear: got %0d cycles want 32", cyc);
    end
    send_key(8'h58, 1'b0);
    send_key(8'h0D, 1'b0);
    n_tests++;
    if (overflow !== 1'b1 || line_ready !== 1'b1 || key_ready !== 1'b1 || cursor !== 6'd1 ||
        line_content[255:240] !== 16'h4849 || line_content[239:0] !== 240'd0) begin
      n_fail++;
      $display("FAIL busy_drop: ov=%b lr=%b kr=%b cur=%0d line=%h want ov=1 lr=1 kr=1 cur=1 line=4849..",
               overflow, line_ready, key_ready, cursor, line_content);
    end
    send_key(8'h0D, 1'b1);
    n_tests++;
    if (line_content[255:248] !== 8'h58 || line_content[247:0] !== 248'd0 ||
        line_ready !== 1'b1 || key_ready !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_commit: line=%h lr=%b kr=%b ov=%b want line=58.. lr=1 kr=0 ov=0",
               line_content, line_ready, key_ready, overflow);
    end
    wait_clear(cyc);
    @(negedge clock);
    line_ack = 1'b1;
    @(posedge clock);
    #1;
    line_ack = 1'b0;
    n_tests++;
    if (line_ready !== 1'b0 || line_content[255:248] !== 8'h58) begin
      n_fail++;
      $display("FAIL ack_clear: lr=%b line=%h want lr=0 line=58..", line_ready, line_content);
    end
    send_key(8'h0D, 1'b0);
    n_tests++;
    if (line_content !== 256'd0 || line_ready !== 1'b1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_commit: line=%h lr=%b ov=%b want 0 1 0", line_content, line_ready, overflow);
    end
    wait_clear(cyc);
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    send_key(8'h51, 1'b0);
    send_key(8'h0D, 1'b0);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (key_ready !== 1'b1 || line_ready !== 1'b0 || cursor !== 6'd0 ||
        edit_content !== 256'd0 || line_content !== 256'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL midclear_reset: kr=%b lr=%b cur=%0d edit=%h line=%h ov=%b want reset values",
               key_ready, line_ready, cursor, edit_content, line_content, overflow);
    end
    @(negedge clock);
    reset = 1'b0;
    send_key(8'h4D, 1'b0);
    n_tests++;
    if (key_ready !== 1'b1 || cursor !== 6'd1 || edit_content[255:248] !== 8'h4D) begin
      n_fail++;
      $display("FAIL midclear_resume: kr=%b cur=%0d top=%h want kr=1 cur=1 top=4d",
               key_ready, cursor, edit_content[255:248]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_typing();
    test_backspace();
    test_commit_clear();
    test_line_full();
    test_busy_and_ack();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
